// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, state encoding and bubble values for the ID/EX stage
package pipe_pkg;

    localparam int REG_NUM_WIDTH = 4;
    localparam int CTRL_WIDTH    = 8;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

    localparam logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0;

    typedef struct packed {
        logic                     valid;
        logic [REG_NUM_WIDTH-1:0] rn_1;
        logic [REG_NUM_WIDTH-1:0] rn_2;
        logic                     write_reg;
        logic                     write_r0;
        logic                     mem_read;
        logic [CTRL_WIDTH-1:0]    ctrl;
    } ex_fields_t;

    localparam ex_fields_t BUBBLE_EX = '{
        valid:     1'b0,
        rn_1:      '0,
        rn_2:      '0,
        write_reg: 1'b0,
        write_r0:  1'b0,
        mem_read:  1'b0,
        ctrl:      BUBBLE_CTRL
    };

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// rtl/id_ex_stage_reg_if.sv - decode-side inputs and EX-side outputs of the ID/EX register
interface id_ex_stage_reg_if
    import pipe_pkg::*;
();

    logic                     id_valid;
    logic [REG_NUM_WIDTH-1:0] id_rn_1;
    logic [REG_NUM_WIDTH-1:0] id_rn_2;
    logic                     id_write_reg;
    logic                     id_write_r0;
    logic                     id_mem_read;
    logic                     id_multicycle;
    logic [CTRL_WIDTH-1:0]    id_ctrl;
    logic                     flush;

    logic                     valid_ex;
    logic [REG_NUM_WIDTH-1:0] rn_1_ex;
    logic [REG_NUM_WIDTH-1:0] rn_2_ex;
    logic                     write_reg_ex;
    logic                     write_r0_ex;
    logic                     mem_read_ex;
    logic [CTRL_WIDTH-1:0]    ctrl_ex;
    logic                     stall_if_id;
    logic                     ex_last;

    modport slave (
        input  id_valid, id_rn_1, id_rn_2, id_write_reg, id_write_r0,
               id_mem_read, id_multicycle, id_ctrl, flush,
        output valid_ex, rn_1_ex, rn_2_ex, write_reg_ex, write_r0_ex,
               mem_read_ex, ctrl_ex, stall_if_id, ex_last
    );

    modport master (
        output id_valid, id_rn_1, id_rn_2, id_write_reg, id_write_r0,
               id_mem_read, id_multicycle, id_ctrl, flush,
        input  valid_ex, rn_1_ex, rn_2_ex, write_reg_ex, write_r0_ex,
               mem_read_ex, ctrl_ex, stall_if_id, ex_last
    );

endinterface

// File: rtl/id_ex_stage_reg_mc_counter.sv
// rtl/id_ex_stage_reg_mc_counter.sv - remaining-cycle counter for multi-cycle EX ops
module mc_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use, flush and multi-cycle hold control
module id_ex_stage_reg
    import pipe_pkg::*;
#(
    parameter int MC_CYCLES = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_stage_reg_if.slave  bus
);

    ex_fields_t ex_q, ex_d;
    logic       kill_q, kill_d;
    logic       cnt_zero;
    logic       mc_load;
    logic       load_use;
    state_e     state;

    assign state = cnt_zero ? RUN : MC_BUSY;

    // Only a register-writing load in EX can create a hazard against the ID sources.
    assign load_use = (state == RUN) && ex_q.valid && ex_q.mem_read && ex_q.write_reg &&
                      bus.id_valid &&
                      ((bus.id_rn_1 == ex_q.rn_1) || (bus.id_rn_2 == ex_q.rn_1));

    always_comb begin
        ex_d    = ex_q;
        kill_d  = kill_q;
        mc_load = 1'b0;
        if (state == MC_BUSY) begin
            // The held op always completes; a flush is remembered for the ID instruction behind it.
            if (bus.flush) begin
                kill_d = 1'b1;
            end
        end else if (bus.flush || kill_q) begin
            ex_d   = BUBBLE_EX;
            kill_d = 1'b0;
        end else if (load_use || !bus.id_valid) begin
            ex_d = BUBBLE_EX;
        end else begin
            ex_d = '{
                valid:     1'b1,
                rn_1:      bus.id_rn_1,
                rn_2:      bus.id_rn_2,
                write_reg: bus.id_write_reg,
                write_r0:  bus.id_write_r0,
                mem_read:  bus.id_mem_read,
                ctrl:      bus.id_ctrl
            };
            mc_load = bus.id_multicycle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q   <= BUBBLE_EX;
            kill_q <= 1'b0;
        end else begin
            ex_q   <= ex_d;
            kill_q <= kill_d;
        end
    end

    mc_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_mc_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (mc_load),
        .load_val_i (CNT_WIDTH'(MC_CYCLES - 1)),
        .dec_i      (state == MC_BUSY),
        .zero_o     (cnt_zero)
    );

    assign bus.valid_ex     = ex_q.valid;
    assign bus.rn_1_ex      = ex_q.rn_1;
    assign bus.rn_2_ex      = ex_q.rn_2;
    assign bus.write_reg_ex = ex_q.write_reg;
    assign bus.write_r0_ex  = ex_q.write_r0;
    assign bus.mem_read_ex  = ex_q.mem_read;
    assign bus.ctrl_ex      = ex_q.ctrl;
    assign bus.stall_if_id  = load_use || (state == MC_BUSY);
    assign bus.ex_last      = ex_q.valid && (state == RUN);

    a_no_multicycle_load: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(bus.id_valid && bus.id_mem_read && bus.id_multicycle)
    );

endmodule
